debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_pkg.sv | 10 +
 rtl/sync_chain.sv | 15 +
 rtl/debounce_sync.sv | 72 +++++++
 tb/tb_debounce_sync.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: debouncer state encoding and glitch counter width shared across the slice.
package debounce_pkg;
  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_RISE_WAIT = 2'b01,
    S_HIGH      = 2'b10,
    S_FALL_WAIT = 2'b11
  } state_t;
  localparam int GLITCH_W = 8;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flop synchronizer for a single asynchronous bit.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or posedge reset)
    if (reset) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes and debounces a noisy level, emitting rise/fall pulses.
// Define DEBOUNCE_GLITCH_CNT_EN to add a saturating count of rejected glitches on glitch_cnt.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic synced;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  wire done = cnt == CW'(DEBOUNCE_CYCLES);
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .d(raw_in),
    .q(synced)
  );
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    case (state)
      S_LOW: if (synced) begin
        state_nxt = S_RISE_WAIT;
        cnt_nxt = CW'(1);
      end
      S_RISE_WAIT:
        if (!synced) state_nxt = S_LOW;
        else if (done) state_nxt = S_HIGH;
        else cnt_nxt = cnt + CW'(1);
      S_HIGH: if (!synced) begin
        state_nxt = S_FALL_WAIT;
        cnt_nxt = CW'(1);
      end
      default:
        if (synced) state_nxt = S_HIGH;
        else if (done) state_nxt = S_LOW;
        else cnt_nxt = cnt + CW'(1);
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_LOW;
      cnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      rise <= state == S_RISE_WAIT && state_nxt == S_HIGH;
      fall <= state == S_FALL_WAIT && state_nxt == S_LOW;
    end
  assign level = state[1];
`ifdef DEBOUNCE_GLITCH_CNT_EN
  wire glitch = (state == S_RISE_WAIT && !synced) || (state == S_FALL_WAIT && synced);
  always_ff @(posedge clk or posedge reset)
    if (reset) glitch_cnt <= '0;
    else if (glitch && glitch_cnt != '1) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
`endif
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: randomized and directed checks of debounce_sync against a run-length reference model.
module tb_debounce_sync;
  localparam int SS = 2;
  localparam int DC = 4;
  logic clk = 1'b0, reset = 1'b1, raw_in = 1'b0;
  logic level, rise, fall;
  int tests = 0, fails = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif
  debounce_sync #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .level(level),
    .rise(rise),
    .fall(fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );
  always #5 clk = ~clk;
  // Reference: a level change is accepted once DC+1 consecutive synchronized samples disagree with it.
  bit m_pipe[SS];
  bit m_level, m_rise, m_fall;
  int run, m_glitch;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (m_pipe[i]) m_pipe[i] = 1'b0;
      m_level = 0; m_rise = 0; m_fall = 0; run = 0; m_glitch = 0;
    end else begin
      bit s;
      s = m_pipe[SS-1];
      for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = raw_in;
      m_rise = 0; m_fall = 0;
      if (s != m_level) begin
        run++;
        if (run == DC + 1) begin
          m_level = s; m_rise = s; m_fall = !s; run = 0;
        end
      end else begin
        if (run > 0 && m_glitch < 255) m_glitch++;
        run = 0;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; raw_in = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({level, rise, fall} !== 3'b000) begin
      fails++; $display("FAIL reset_outputs got %b%b%b want 000", level, rise, fall);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    tests++;
    if (glitch_cnt !== 8'd0) begin fails++; $display("FAIL reset_glitch got %0d want 0", glitch_cnt); end
`endif
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rise_latency();
    raw_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      tests++;
      if (level !== (e >= SS + DC + 1) || rise !== (e == SS + DC + 1) || fall !== 1'b0) begin
        fails++; $display("FAIL rise_latency edge %0d got l%b r%b f%b", e, level, rise, fall);
      end
    end
  endtask

  task automatic test_fall_glitch();
    raw_in = 1'b0;
    repeat (3) @(negedge clk);
    raw_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests++;
      if (level !== 1'b1 || fall !== 1'b0) begin
        fails++; $display("FAIL fall_glitch cycle %0d got l%b f%b want l1 f0", c, level, fall);
      end
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    tests++;
    if (glitch_cnt !== 8'(m_glitch) || m_glitch != 1) begin
      fails++; $display("FAIL fall_glitch_cnt got %0d want 1 (model %0d)", glitch_cnt, m_glitch);
    end
`endif
    raw_in = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_rise_glitch();
    raw_in = 1'b1;
    repeat (2) @(negedge clk);
    raw_in = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests++;
      if (level !== 1'b0 || rise !== 1'b0 || level !== m_level) begin
        fails++; $display("FAIL rise_glitch cycle %0d got l%b r%b want l0 r0", c, level, rise);
      end
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    tests++;
    if (glitch_cnt !== 8'(m_glitch) || m_glitch != 2) begin
      fails++; $display("FAIL rise_glitch_cnt got %0d want 2 (model %0d)", glitch_cnt, m_glitch);
    end
`endif
  endtask

  task automatic test_reset_midwait();
    raw_in = 1'b1;
    repeat (SS + 3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({level, rise, fall} !== 3'b000) begin
      fails++; $display("FAIL midwait_reset got %b%b%b want 000", level, rise, fall);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    tests++;
    if (glitch_cnt !== 8'd0) begin fails++; $display("FAIL midwait_glitch got %0d want 0", glitch_cnt); end
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      tests++;
      if (level !== (e >= SS + DC + 1) || rise !== (e == SS + DC + 1)) begin
        fails++; $display("FAIL midwait_release edge %0d got l%b r%b", e, level, rise);
      end
    end
    raw_in = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_glitch_saturate();
    for (int g = 0; g < 310; g++) begin
      raw_in = 1'b1; @(negedge clk);
      raw_in = 1'b0; @(negedge clk);
      if (g == 299 || g == 309) begin
        tests++;
        if (level !== 1'b0) begin fails++; $display("FAIL saturate_level got %b want 0", level); end
      end
    end
    repeat (4) @(negedge clk);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    tests++;
    if (glitch_cnt !== 8'd255 || m_glitch != 255) begin
      fails++; $display("FAIL saturate_cnt got %0d want 255 (model %0d)", glitch_cnt, m_glitch);
    end
`endif
  endtask

  task automatic test_toggle();
    int rises = 0, falls = 0;
    for (int c = 0; c < 6 * 12 + 12; c++) begin
      raw_in = c < 72 ? ((c / 6) % 2 == 0) : 1'b0;
      @(negedge clk);
      rises += int'(rise === 1'b1);
      falls += int'(fall === 1'b1);
      tests++;
      if ($isunknown(level) || level !== m_level || rise !== m_rise || fall !== m_fall) begin
        fails++; $display("FAIL toggle cycle %0d got l%b r%b f%b want l%b r%b f%b",
                          c, level, rise, fall, m_level, m_rise, m_fall);
      end
    end
    tests++;
    if (rises != 6 || falls != 6) begin
      fails++; $display("FAIL toggle_pulses got %0d/%0d want 6/6", rises, falls);
    end
  endtask

  task automatic test_random();
    int left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (left == 0) begin
        raw_in = ~raw_in;
        left = $urandom_range(1, 9);
      end
      left--;
      @(negedge clk);
      tests++;
      if (level !== m_level || rise !== m_rise || fall !== m_fall || (rise && fall)) begin
        fails++; $display("FAIL random cycle %0d got l%b r%b f%b want l%b r%b f%b",
                          c, level, rise, fall, m_level, m_rise, m_fall);
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      tests++;
      if (glitch_cnt !== 8'(m_glitch)) begin
        fails++; $display("FAIL random_glitch cycle %0d got %0d want %0d", c, glitch_cnt, m_glitch);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_fall_glitch();
    test_rise_glitch();
    test_reset_midwait();
    test_glitch_saturate();
    test_toggle();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
